// File: rtl/regfile_mp.sv
// Multi-port register file: 1 write port, NUM_RD registered read ports (1-cycle latency), write->read bypass.
// busy is high during a background clear. While busy, writes and clr are dropped and reads are still served.
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       clr,
    output logic                       busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int              DEPTH_M1 = DEPTH - 1;
    localparam logic [ADDR_W:0] DEPTH_X  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_PTR = DEPTH_M1[ADDR_W-1:0];

    logic [DATA_W-1:0]               mem [DEPTH];
    logic [0:0]                      state;
    logic [ADDR_W-1:0]               clr_ptr;
    logic                            busy_q;
    logic                            wr_acc;
    logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_val;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_q;
    logic [NUM_RD-1:0]               vld_q;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign ra     = rd_addr;
    assign wr_acc = wr_en && !busy_q && in_range(wr_addr) && !is_zero_reg(wr_addr);

    // Out-of-range and zero-register reads never touch the array.
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!in_range(ra[p]) || is_zero_reg(ra[p])) begin
                rd_val[p] = '0;
            end else if ((BYPASS != 0) && wr_acc && (wr_addr == ra[p])) begin
                rd_val[p] = wr_data;
            end else begin
                rd_val[p] = mem[ra[p]];
            end
        end
    end

    // wr_acc is already gated by busy, so clear and write never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
            busy_q  <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (clr) begin
                state   <= ST_CLEAR;
                clr_ptr <= '0;
                busy_q  <= 1'b1;
            end
        end else begin
            if (clr_ptr == LAST_PTR) begin
                state   <= ST_IDLE;
                clr_ptr <= '0;
                busy_q  <= 1'b0;
            end else begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            vld_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                vld_q[p] <= rd_en[p];
                if (rd_en[p]) begin
                    rd_q[p] <= rd_val[p];
                end
            end
        end
    end

    assign rd_data  = rd_q;
    assign rd_valid = vld_q;
    assign busy     = busy_q;

endmodule
